// File: rtl/alu_pipe_if.sv
// Request/response bundle for alu_pipe: issue side (in_*), result side (out_*),
// per-result flags and the architectural carry flag.
interface alu_pipe_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       sel;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] tag_out;
    logic             carry_out;
    logic             zero;
    logic             neg;
    logic             overflow;
    logic             parity;
    logic             c_flag;

    modport master (
        output in_valid, sel, op1, op2, tag_in, out_ready,
        input  in_ready, out_valid, result, tag_out,
        input  carry_out, zero, neg, overflow, parity, c_flag
    );

    modport slave (
        input  in_valid, sel, op1, op2, tag_in, out_ready,
        output in_ready, out_valid, result, tag_out,
        output carry_out, zero, neg, overflow, parity, c_flag
    );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake, persistent carry flag for
// multi-word arithmetic and variable-amount barrel shifts.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input logic       clk,
    input logic       rst,
    alu_pipe_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [3:0] {
        OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_NEG, OP_INC, OP_DEC, OP_PASS,
        OP_AND, OP_OR,  OP_XOR, OP_NOT, OP_ASL, OP_ASR, OP_LSL, OP_LSR
    } op_e;

    op_e                     op;
    logic                    accept;
    logic                    c_flag;
    logic [WIDTH-1:0]        x;
    logic [WIDTH-1:0]        y;
    logic                    cin;
    logic                    is_sub;
    logic [WIDTH:0]          arith;
    logic                    arith_ov;
    logic [SHW-1:0]          amt;
    logic [WIDTH:0]          shl_ext;
    logic [WIDTH:0]          shr_ext;
    logic signed [WIDTH:0]   asr_ext;
    logic [WIDTH-1:0]        nxt_result;
    logic                    nxt_carry;
    logic                    nxt_ov;
    logic                    upd_c;

    assign op           = op_e'(bus.sel);
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign bus.c_flag   = c_flag;

    // All add/sub flavours share one WIDTH+1 adder; NEG is 0-op1, INC/DEC use 1.
    always_comb begin
        x      = bus.op1;
        y      = bus.op2;
        cin    = 1'b0;
        is_sub = 1'b0;
        case (op)
            OP_ADC:  cin = c_flag;
            OP_SUB:  is_sub = 1'b1;
            OP_SBC:  begin is_sub = 1'b1; cin = c_flag; end
            OP_NEG:  begin is_sub = 1'b1; x = '0; y = bus.op1; end
            OP_INC:  y = WIDTH'(1);
            OP_DEC:  begin is_sub = 1'b1; y = WIDTH'(1); end
            default: ;
        endcase
    end

    assign arith = is_sub ? ({1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, cin})
                          : ({1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin});
    assign arith_ov = (is_sub ? (x[MSB] != y[MSB]) : (x[MSB] == y[MSB]))
                      && (arith[MSB] != x[MSB]);

    // The extra bit on each shifter catches the last bit shifted out (0 when amt=0).
    assign amt     = bus.op2[SHW-1:0];
    assign shl_ext = {1'b0, bus.op1} << amt;
    assign shr_ext = {bus.op1, 1'b0} >> amt;
    assign asr_ext = $signed({bus.op1, 1'b0}) >>> amt;

    always_comb begin
        nxt_result = bus.op1;
        nxt_carry  = 1'b0;
        nxt_ov     = 1'b0;
        upd_c      = 1'b1;
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_NEG, OP_INC, OP_DEC: begin
                nxt_result = arith[WIDTH-1:0];
                nxt_carry  = arith[WIDTH];
                nxt_ov     = arith_ov;
            end
            OP_PASS: upd_c = 1'b0;
            OP_AND:  begin nxt_result = bus.op1 & bus.op2; upd_c = 1'b0; end
            OP_OR:   begin nxt_result = bus.op1 | bus.op2; upd_c = 1'b0; end
            OP_XOR:  begin nxt_result = bus.op1 ^ bus.op2; upd_c = 1'b0; end
            OP_NOT:  begin nxt_result = ~bus.op1;          upd_c = 1'b0; end
            OP_ASL, OP_LSL: begin
                nxt_result = shl_ext[WIDTH-1:0];
                nxt_carry  = shl_ext[WIDTH];
                nxt_ov     = (op == OP_ASL) && (shl_ext[MSB] != bus.op1[MSB]);
            end
            OP_ASR: begin
                nxt_result = asr_ext[WIDTH:1];
                nxt_carry  = asr_ext[0];
            end
            OP_LSR: begin
                nxt_result = shr_ext[WIDTH:1];
                nxt_carry  = shr_ext[0];
            end
            default: ;
        endcase
    end

    // Single output register: loads on accept, empties on a drain with no new op.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.tag_out   <= '0;
            bus.carry_out <= 1'b0;
            bus.zero      <= 1'b0;
            bus.neg       <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.parity    <= 1'b0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.result    <= nxt_result;
            bus.tag_out   <= bus.tag_in;
            bus.carry_out <= nxt_carry;
            bus.zero      <= (nxt_result == '0);
            bus.neg       <= nxt_result[MSB];
            bus.overflow  <= nxt_ov;
            bus.parity    <= ~^nxt_result;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_flag <= 1'b0;
        end else if (accept && upd_c) begin
            c_flag <= nxt_carry;
        end
    end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered ALU with a valid/ready handshake, a persistent carry flag for multi-word arithmetic, and barrel shifts by a variable amount. It takes one operation per cycle from the issuing datapath, holds a single output register that honours downstream backpressure, and returns a tagged result with per-operation flags. It replaces the fixed 16-bit combinational ALU wherever results are consumed through a handshake.

## Interface
- WIDTH, 16, operand/result width (≥4, power of two).
- TAG_W, 4, width of the pass-through transaction tag.
- SHW, $clog2(WIDTH), derived: shift-amount width (op2[SHW-1:0]).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- sel  in  4  operation code (below).
- op1, op2  in  WIDTH  operands.
- tag_in  in  TAG_W  returned unchanged with the result.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- result  out  WIDTH  operation result.
- tag_out  out  TAG_W  tag of the result.
- carry_out, zero, neg, overflow, parity  out  1 each  flags of the result.
- c_flag  out  1  stored carry flag (architectural state).

## Operation
- Opcodes: 0 ADD op1+op2; 1 ADC op1+op2+c_flag; 2 SUB op1-op2; 3 SBC op1-op2-c_flag; 4 NEG 0-op1; 5 INC op1+1; 6 DEC op1-1; 7 PASS op1; 8 AND; 9 OR; 10 XOR; 11 NOT op1; 12 ASL; 13 ASR; 14 LSL; 15 LSR. Shift ops move op1 by amt = op2[SHW-1:0].
- Arithmetic is computed at WIDTH+1 bits, and result is the low WIDTH bits.
- carry_out for add ops (0,1,5) is the carry out of bit WIDTH-1.
- carry_out for sub ops (2,3,4,6) is the borrow: 1 when the unsigned minuend < subtrahend (+ carry-in).
- NEG: carry_out=1 iff op1≠0.
- overflow for add ops: operand signs equal and result sign differs.
- overflow for sub ops: operand signs differ and result sign differs from op1 sign.
- NEG: overflow=1 iff op1 = 1<<(WIDTH-1).
- Shifts, amt>0: carry_out = last bit shifted out. ASR fills with op1 sign. ASL ≡ LSL, except overflow=1 if the result sign ≠ op1 sign.
- Shifts, amt=0: result=op1, carry_out=0, overflow=0.
- Ops 7–11: carry_out=0, overflow=0.
- zero=(result==0); neg=result[WIDTH-1]; parity = XNOR of result bits (1 = even number of ones).
- c_flag update: on acceptance of ops 0–6 and 12–15, c_flag ← carry_out. Ops 7–11 leave c_flag unchanged.
- ADC/SBC use c_flag as it stands before the accepting edge.
- Back-to-back dependent ops see the updated flag, because each op updates c_flag on its own accept edge.

## Timing
- Reset values: out_valid=0; result, tag_out and all flags = 0; c_flag=0. in_ready=1 in the first cycle after reset.
- in_ready = !out_valid | out_ready (combinational from out_ready; no path from in_valid).
- Latency: an op accepted at edge N shows on result/flags with out_valid=1 after edge N.
- Throughput: 1 op/cycle while out_ready=1.
- Hold while stalled: while out_valid & !out_ready, result, tag_out, flags and c_flag hold stable, and no new op is accepted.
- Simultaneous drain+accept: out_valid stays 1 and the register loads the new op.
- Drain without accept: out_valid←0.
- Reset mid-operation: rst overrides all handshakes. The held result is discarded (no out_valid pulse), c_flag clears, and an op presented in the rst cycle is not accepted.
- sel/op values while in_valid=0 have no effect on any state.

## Test plan
- WIDTH=16, ADD 0xFFFF+0x0001 → result 0x0000, carry_out=1, zero=1, overflow=0, parity=1, c_flag=1.
  - Next cycle: ADC 0x0001+0x0001 → 0x0003, carry_out=0, c_flag=0.
- SUB 0x8000-0x0001 → 0x7FFF, carry_out=0, overflow=1, neg=0.
  - Then SBC 0x0000-0x0000 with c_flag=0 → 0x0000, zero=1.
- Shifts:
  - LSR 0x8001 by 4 → 0x0800, carry_out=0.
  - ASR 0x8018 by 4 → 0xF801, carry_out=1.
  - ASL 0x4000 by 1 → 0x8000, overflow=1.
  - LSL 0x1234 by 0 → 0x1234, carry_out=0.
- Backpressure:
  - Hold out_ready=0 for 3 cycles with in_valid=1, tags 1 then 2. Required: tag 1 result held stable, in_ready=0.
  - Raise out_ready: tag 2 appears on the following cycle. No loss or duplication; c_flag is updated only once per op.
- Reset with out_valid=1 and c_flag=1 → next cycle out_valid=0 and c_flag=0. Then ADC 0x0000+0x0000 → 0x0000, zero=1.
- WIDTH=8 instance: NEG 0x80 → 0x80, carry_out=1, overflow=1, neg=1. DEC 0x00 → 0xFF, carry_out=1.
